piso_serializer: RTL and testbench

Parallel-in serial-out frame transmitter: accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `so`. The block qualifies each bit cell with `so_en` and marks frame boundaries. It is the transmit end of the serial bit-stream that the team's serial-in shift-register receivers consume. It drives them directly from a parallel producer (register file, counter, or test pattern source).

---
 rtl/piso_serializer.sv | 177 +++++++++++++++++
 tb/tb_piso_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out frame transmitter with one-entry holding register.
// Define PISO_PARITY_EN to append an even-parity cell to every frame.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_en,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef PISO_PARITY_EN
    PAR   = 2'd2,
`endif
    GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q, hold_full_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             load;
  logic             so_d, so_en_d, fs_d, done_d, busy_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // load = end of a frame (or idle) with a word waiting in the holding register
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
`ifdef PISO_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: load = hold_full_q;
      SHIFT: begin
        if (bit_cnt_q != BIT_LAST) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          sh_d = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
        end else begin
`ifdef PISO_PARITY_EN
          state_d = PAR;
`else
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
            load    = hold_full_q;
          end
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        if (GAP_CYCLES > 0) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          state_d = IDLE;
          load    = hold_full_q;
        end
      end
`endif
      GAP: begin
        if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          load    = hold_full_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d   = SHIFT;
      sh_d      = hold_q;
      bit_cnt_d = '0;
`ifdef PISO_PARITY_EN
      par_d     = ^hold_q;
`endif
    end
    hold_full_d = hold_full_q;
    if (load)                          hold_full_d = 1'b0;
    else if (din_valid && !hold_full_q) hold_full_d = 1'b1;
  end

  // outputs describe the cell entered on the coming edge
  always_comb begin
    so_d    = 1'b0;
    so_en_d = 1'b0;
    fs_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      SHIFT: begin
        so_d    = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
        so_en_d = 1'b1;
        fs_d    = (bit_cnt_d == '0);
`ifndef PISO_PARITY_EN
        done_d  = (bit_cnt_d == BIT_LAST);
`endif
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        so_d    = par_d;
        so_en_d = 1'b1;
        done_d  = 1'b1;
      end
`endif
      default: ;
    endcase
    busy_d = (state_d != IDLE) || hold_full_d;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      so          <= 1'b0;
      so_en       <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      sh_q        <= sh_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      so          <= so_d;
      so_en       <= so_en_d;
      frame_start <= fs_d;
      done        <= done_d;
      busy        <= busy_d;
`ifdef PISO_PARITY_EN
      par_q       <= par_d;
`endif
      if (din_valid && !hold_full_q) hold_q <= din;
    end
  end

  assign din_ready = !hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three parameter sets driven by shared stimulus
// and checked every cycle against a frame-position reference model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk;
  logic         clear_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy [3];
  logic         so [3];
  logic         so_en [3];
  logic         fs [3];
  logic         dn [3];
  logic         busy [3];

  int n_chk;
  int n_err;
  int cyc;

  int           pos [3];
  logic [W-1:0] word [3];
  logic         hf [3];
  logic [W-1:0] hw [3];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) u0 (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy[0]), .so(so[0]), .so_en(so_en[0]),
    .frame_start(fs[0]), .done(dn[0]), .busy(busy[0]));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) u1 (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy[1]), .so(so[1]), .so_en(so_en[1]),
    .frame_start(fs[1]), .done(dn[1]), .busy(busy[1]));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u2 (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy[2]), .so(so[2]), .so_en(so_en[2]),
    .frame_start(fs[2]), .done(dn[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gap_of(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  task automatic chk(input string tag, input logic [5:0] got,
                     input logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b exp=%b (so,en,fs,done,busy,rdy)",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i]  = -1;
      hf[i]   = 1'b0;
      word[i] = '0;
      hw[i]   = '0;
    end
  endtask

  // a frame is a run of positions 0..period-1; -1 means idle
  task automatic model_edge(input int i);
    int   period;
    logic acc;
    logic ended;
    period = W + PAR + gap_of(i);
    acc    = din_valid && !hf[i];
    ended  = (pos[i] < 0) || (pos[i] == period - 1);
    if (ended && hf[i]) begin
      pos[i]  = 0;
      word[i] = hw[i];
      hf[i]   = 1'b0;
    end else if (ended) begin
      pos[i] = -1;
    end else begin
      pos[i]++;
    end
    if (acc) begin
      hf[i] = 1'b1;
      hw[i] = din;
    end
  endtask

  function automatic logic [5:0] model_out(input int i);
    logic s, e, f, d;
    int   p;
    int   idx;
    s = 1'b0; e = 1'b0; f = 1'b0; d = 1'b0;
    p = pos[i];
    if (p >= 0 && p < W) begin
      idx = msb_of(i) ? (W - 1 - p) : p;
      s = word[i][idx];
      e = 1'b1;
      f = (p == 0);
      d = (p == W - 1) && (PAR == 0);
    end else if (p == W && PAR == 1) begin
      s = ^word[i];
      e = 1'b1;
      d = 1'b1;
    end
    return {s, e, f, d, (p >= 0) || hf[i], !hf[i]};
  endfunction

  function automatic logic [5:0] dut_out(input int i);
    return {so[i], so_en[i], fs[i], dn[i], busy[i], rdy[i]};
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d", i), dut_out(i), model_out(i));
  endtask

  task automatic tick();
    @(posedge clk);
    if (clear_n)
      for (int i = 0; i < 3; i++) model_edge(i);
    cyc++;
    #1;
    check_all();
  endtask

  // asynchronous reset asserted between edges, checked before any edge
  task automatic mid_reset(input int hold);
    #2;
    clear_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (hold) tick();
    clear_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    clear_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    model_reset();
    #2;
    check_all();
    repeat (2) tick();
    clear_n = 1'b1;
    repeat (2) tick();

    din = 4'b1011;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (8) tick();

    din = 4'b1011;
    din_valid = 1'b1;
    repeat (3) tick();
    din = 4'b0110;
    repeat (4) tick();
    din_valid = 1'b0;
    repeat (12) tick();

    din = 4'b1011;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (2) tick();
    mid_reset(2);
    repeat (4) tick();
    din = 4'b0110;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (8) tick();

    din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din = W'($urandom);
      repeat (4) tick();
    end
    din_valid = 1'b0;
    repeat (10) tick();

    for (int k = 0; k < 800; k++) begin
      din_valid = ($urandom_range(0, 99) < 60);
      din = W'($urandom);
      if ($urandom_range(0, 149) == 0) mid_reset(1);
      tick();
    end
    din_valid = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
